dmem_lsu: RTL

//  Parametrised data memory with a byte-lane load/store unit for the MEM stage of the pipelined core.

---
 rtl/dmem_lsu.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Word-organised data memory with a RISC-V byte-lane load/store unit for the MEM stage.
// A zero-fill INIT sequence runs after every reset before requests are accepted.
module dmem_lsu #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_misalign,
    output logic        o_init_done
);

    typedef enum logic {StInit, StRun} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic [ADDR_W-1:0]   w_init_cnt_d;
    logic [31:0]         r_mem [DEPTH];
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_misalign;

    logic                w_accept;
    logic [ADDR_W-1:0]   w_idx;
    logic [1:0]          w_lane;
    logic                w_bad;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata_rep;
    logic [31:0]         w_word;
    logic [31:0]         w_shifted;
    logic [31:0]         w_load;
    logic                w_wr_en;
    logic                w_unused;

    // Address bits above the word index are ignored so the array aliases.
    assign w_unused = ^i_req_addr[31:ADDR_W+2];

    assign w_accept = i_req_valid & o_req_ready;
    assign w_idx    = i_req_addr[ADDR_W+1:2];
    assign w_lane   = i_req_addr[1:0];
    assign w_wr_en  = w_accept & i_req_we & ~w_bad;

    always_comb begin
        w_state_d    = r_state;
        w_init_cnt_d = r_init_cnt;
        case (r_state)
            StInit: begin
                w_init_cnt_d = r_init_cnt + 1'b1;
                if (r_init_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_d = StRun;
                end
            end
            default: w_state_d = StRun;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StInit;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_init_cnt <= w_init_cnt_d;
        end
    end

    assign o_req_ready = (r_state == StRun);
    assign o_init_done = (r_state == StRun);

    // Stores only accept B/H/W; loads additionally accept BU/HU.
    always_comb begin
        w_bad       = 1'b0;
        w_be        = 4'b0000;
        w_wdata_rep = i_req_wdata;
        unique case (i_req_funct3)
            3'b000: begin
                w_be        = 4'b0001 << w_lane;
                w_wdata_rep = {4{i_req_wdata[7:0]}};
            end
            3'b001: begin
                w_bad       = w_lane[0];
                w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{i_req_wdata[15:0]}};
            end
            3'b010: begin
                w_bad = (w_lane != 2'b00);
                w_be  = 4'b1111;
            end
            3'b100: w_bad = i_req_we;
            3'b101: w_bad = i_req_we | w_lane[0];
            default: w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_word    = r_mem[w_idx];
        w_shifted = w_word >> {w_lane, 3'b000};
        w_load    = w_word;
        case (i_req_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'h000000, w_shifted[7:0]};
            3'b101:  w_load = {16'h0000, w_shifted[15:0]};
            default: w_load = w_word;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (r_state == StInit) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // Response data and flag hold their last value while no response is pending.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_misalign <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_rdata    <= (i_req_we | w_bad) ? 32'h0 : w_load;
            r_rsp_misalign <= w_bad;
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_misalign = r_rsp_misalign;

endmodule
